prime_gen: RTL

PRIME_GEN -- requirements
Module: prime_gen

---
 rtl/prime_pkg.sv | 15 +
 rtl/prime_mod_unit.sv | 73 +++++++
 rtl/prime_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/prime_pkg.sv
// Shared types and defaults for the prime generator: FSM state encoding and default width.
package prime_pkg;

    localparam int PRIME_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NEXT   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_DIVIDE = 3'd3,
        ST_EMIT   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/prime_mod_unit.sv
// Serial restoring remainder unit: one quotient bit per cycle, rdy pulses WIDTH+1 cycles after go.
module prime_mod_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             rdy,
    output logic [WIDTH-1:0] rem
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_rem;
    logic             r_rdy;

    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;

    // One restoring step; when the shifted value is >= divisor the difference fits in WIDTH bits.
    always_comb begin
        w_shift   = {r_rem, r_dvd[WIDTH-1]};
        w_ge      = (w_shift >= {1'b0, r_dsr});
        w_rem_nxt = w_shift[WIDTH-1:0];
        if (w_ge) begin
            w_rem_nxt = w_shift[WIDTH-1:0] - r_dsr;
        end else begin
            w_rem_nxt = w_shift[WIDTH-1:0];
        end
    end

    // Operand load on go, then WIDTH iterations; go while running is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_dvd  <= '0;
            r_dsr  <= '0;
            r_rem  <= '0;
            r_rdy  <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (!r_busy) begin
                if (go) begin
                    r_busy <= 1'b1;
                    r_cnt  <= CW'(WIDTH);
                    r_dvd  <= dividend;
                    r_dsr  <= divisor;
                    r_rem  <= '0;
                end
            end else begin
                r_rem <= w_rem_nxt;
                r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_rdy  <= 1'b1;
                end
            end
        end
    end

    assign rdy = r_rdy;
    assign rem = r_rem;

endmodule

// File: rtl/prime_gen.sv
// Trial-division prime generator: streams every prime in [2, limit] in ascending order over valid/ready.
module prime_gen
    import prime_pkg::*;
#(
    parameter int WIDTH = PRIME_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] prime,
    output logic             busy,
    output logic             done
);

    localparam int SW = 2 * WIDTH + 2;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_lim, w_lim_nxt;
    logic [WIDTH:0]   r_cand, w_cand_nxt;
    logic [WIDTH-1:0] r_d, w_d_nxt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_prime;
    logic             r_busy;
    logic             r_done;

    logic             w_div_go;
    logic             w_div_rdy;
    logic [WIDTH-1:0] w_div_rem;
    logic [SW-1:0]    w_sq;
    logic             w_is_prime;

    // Squared divisor is formed wide enough that it can never overflow.
    assign w_sq       = SW'(r_d) * SW'(r_d);
    assign w_is_prime = (w_sq > SW'(r_cand));

    prime_mod_unit #(.WIDTH(WIDTH)) u_mod (
        .clk      (clk),
        .reset    (reset),
        .go       (w_div_go),
        .dividend (r_cand[WIDTH-1:0]),
        .divisor  (r_d),
        .rdy      (w_div_rdy),
        .rem      (w_div_rem)
    );

    // State and datapath registers, plus outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_lim       <= '0;
            r_cand      <= '0;
            r_d         <= '0;
            r_out_valid <= 1'b0;
            r_prime     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lim       <= w_lim_nxt;
            r_cand      <= w_cand_nxt;
            r_d         <= w_d_nxt;
            r_out_valid <= (w_state_nxt == ST_EMIT);
            r_prime     <= (w_state_nxt == ST_EMIT) ? w_cand_nxt[WIDTH-1:0] : r_prime;
            r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
            r_done      <= (w_state_nxt == ST_DONE);
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        w_state_nxt = r_state;
        w_lim_nxt   = r_lim;
        w_cand_nxt  = r_cand;
        w_d_nxt     = r_d;
        w_div_go    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_lim_nxt   = limit;
                    w_cand_nxt  = {{(WIDTH-1){1'b0}}, 2'd2};
                    w_state_nxt = ST_NEXT;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_NEXT: begin
                if (r_cand > {1'b0, r_lim}) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_d_nxt     = {{(WIDTH-2){1'b0}}, 2'd2};
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_is_prime) begin
                    w_state_nxt = ST_EMIT;
                end else begin
                    w_div_go    = 1'b1;
                    w_state_nxt = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (w_div_rdy) begin
                    if (w_div_rem == '0) begin
                        w_cand_nxt  = r_cand + {{WIDTH{1'b0}}, 1'b1};
                        w_state_nxt = ST_NEXT;
                    end else begin
                        w_d_nxt     = r_d + {{(WIDTH-1){1'b0}}, 1'b1};
                        w_state_nxt = ST_CHECK;
                    end
                end else begin
                    w_state_nxt = ST_DIVIDE;
                end
            end
            ST_EMIT: begin
                if (r_out_valid && out_ready) begin
                    w_cand_nxt  = r_cand + {{WIDTH{1'b0}}, 1'b1};
                    w_state_nxt = ST_NEXT;
                end else begin
                    w_state_nxt = ST_EMIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign out_valid = r_out_valid;
    assign prime     = r_prime;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
